// File: rtl/key_event_fsm_if.sv
// key_event_fsm_if: key level in, classified event pulses and demo LED register out.
interface key_event_fsm_if;
  logic       key_db;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic [3:0] led;
  modport master (output key_db, input short_press, long_press, double_click, led);
  modport slave  (input key_db, output short_press, long_press, double_click, led);
endinterface

// File: rtl/key_event_fsm.sv
// key_event_fsm: classifies debounced active-low key presses into short, long and double-click pulses.
module key_event_fsm #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 15_000_000,
  parameter int CNT_W         = 26
) (
  input logic           sys_clk,
  input logic           rst,
  key_event_fsm_if.slave k
);
  typedef enum logic [1:0] {IDLE, PRESS1, GAP, WAIT_REL} state_e;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             short_q, long_q, dclick_q;
  logic [3:0]       led_q;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      led_q    <= 4'h0;
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      case (state_q)
        IDLE: if (!k.key_db) begin
          state_q <= PRESS1;
          cnt_q   <= '0;
        end
        // release wins over terminal count
        PRESS1: if (k.key_db) begin
          state_q <= GAP;
          cnt_q   <= '0;
        end else if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
          long_q  <= 1'b1;
          led_q   <= 4'h0;
          state_q <= WAIT_REL;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        // second press wins over terminal count
        GAP: if (!k.key_db) begin
          dclick_q <= 1'b1;
          led_q    <= ~led_q;
          state_q  <= WAIT_REL;
          cnt_q    <= '0;
        end else if (cnt_q == CNT_W'(DCLICK_CYCLES - 1)) begin
          short_q <= 1'b1;
          led_q   <= led_q + 4'h1;
          state_q <= IDLE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        WAIT_REL: if (k.key_db) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end
  assign k.short_press  = short_q;
  assign k.long_press   = long_q;
  assign k.double_click = dclick_q;
  assign k.led          = led_q;
endmodule

// File: tb/tb_key_event_fsm.sv
// tb_key_event_fsm: directed scenario tests for key_event_fsm with shortened timing parameters.
module tb_key_event_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  key_event_fsm_if kif();
  key_event_fsm #(.LONG_CYCLES(20), .DCLICK_CYCLES(10), .CNT_W(5)) dut (
    .sys_clk(clk),
    .rst(rst),
    .k(kif)
  );
  always #5 clk = ~clk;
  int n = 0;
  int err = 0;
  int cyc = 0;
  int sp_n, lp_n, dc_n, sp_cyc, lp_cyc, dc_cyc;
  logic armed = 1'b0;
  logic prev_any = 1'b0;
  task automatic clear_counts;
    sp_n = 0; lp_n = 0; dc_n = 0;
    sp_cyc = -1; lp_cyc = -1; dc_cyc = -1;
  endtask
  // advance one edge, then observe registered outputs and run per-cycle invariants
  task automatic tick;
    logic any;
    @(posedge clk);
    #1;
    cyc++;
    if (armed) begin
      n++;
      if ($isunknown({kif.short_press, kif.long_press, kif.double_click, kif.led})) begin
        err++;
        $display("FAIL xcheck cyc=%0d got sp=%b lp=%b dc=%b led=%h want no X", cyc,
                 kif.short_press, kif.long_press, kif.double_click, kif.led);
      end
      any = kif.short_press | kif.long_press | kif.double_click;
      n++;
      if ((int'(kif.short_press) + int'(kif.long_press) + int'(kif.double_click) > 1) || (prev_any && any)) begin
        err++;
        $display("FAIL pulse_shape cyc=%0d got sp=%b lp=%b dc=%b prev=%b want single 1-cycle pulse", cyc,
                 kif.short_press, kif.long_press, kif.double_click, prev_any);
      end
      prev_any = any;
    end
    if (kif.short_press === 1'b1) begin sp_n++; sp_cyc = cyc; end
    if (kif.long_press === 1'b1) begin lp_n++; lp_cyc = cyc; end
    if (kif.double_click === 1'b1) begin dc_n++; dc_cyc = cyc; end
  endtask
  task automatic test_reset;
    int e;
    rst = 1'b1; kif.key_db = 1'b1;
    tick();
    armed = 1'b1;
    rst = 1'b0; kif.key_db = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n++;
      if ({kif.short_press, kif.long_press, kif.double_click, kif.led} !== 7'b0) begin
        err++;
        $display("FAIL reset_outputs i=%0d got sp=%b lp=%b dc=%b led=%h want all 0", i,
                 kif.short_press, kif.long_press, kif.double_click, kif.led);
      end
    end
    rst = 1'b0;
    clear_counts();
    tick();
    e = cyc;
    for (int i = 0; i < 40 && lp_n == 0; i++) tick();
    n++;
    if (lp_cyc - e !== 20) begin
      err++;
      $display("FAIL reset_long_latency got %0d want 20", lp_cyc - e);
    end
    kif.key_db = 1'b1;
    repeat (2) tick();
    n++;
    if (lp_n !== 1 || kif.led !== 4'h0) begin
      err++;
      $display("FAIL reset_long_count got lp=%0d led=%h want 1 0", lp_n, kif.led);
    end
  endtask
  task automatic test_short;
    int g;
    clear_counts();
    kif.key_db = 1'b0;
    repeat (5) tick();
    kif.key_db = 1'b1;
    tick();
    g = cyc;
    for (int i = 0; i < 30 && sp_n == 0; i++) tick();
    repeat (5) tick();
    n++;
    if (sp_cyc - g !== 10) begin
      err++;
      $display("FAIL short_latency got %0d want 10", sp_cyc - g);
    end
    n++;
    if (sp_n !== 1 || lp_n !== 0 || dc_n !== 0 || kif.led !== 4'h1) begin
      err++;
      $display("FAIL short_events got sp=%0d lp=%0d dc=%0d led=%h want 1 0 0 1", sp_n, lp_n, dc_n, kif.led);
    end
  endtask
  task automatic test_long;
    int e;
    clear_counts();
    kif.key_db = 1'b0;
    tick();
    e = cyc;
    repeat (29) tick();
    kif.key_db = 1'b1;
    repeat (15) tick();
    n++;
    if (lp_cyc - e !== 20) begin
      err++;
      $display("FAIL long_latency got %0d want 20", lp_cyc - e);
    end
    n++;
    if (lp_n !== 1 || sp_n !== 0 || dc_n !== 0 || kif.led !== 4'h0) begin
      err++;
      $display("FAIL long_events got lp=%0d sp=%0d dc=%0d led=%h want 1 0 0 0", lp_n, sp_n, dc_n, kif.led);
    end
    n++;
    if (2'(dut.state_q) !== 2'd0) begin
      err++;
      $display("FAIL long_idle got state=%0d want 0", 2'(dut.state_q));
    end
  endtask
  task automatic test_dclick;
    int p;
    kif.key_db = 1'b0;
    repeat (3) tick();
    kif.key_db = 1'b1;
    repeat (14) tick();
    n++;
    if (kif.led !== 4'h1) begin
      err++;
      $display("FAIL dclick_setup got led=%h want 1", kif.led);
    end
    clear_counts();
    kif.key_db = 1'b0;
    repeat (3) tick();
    kif.key_db = 1'b1;
    repeat (4) tick();
    kif.key_db = 1'b0;
    p = cyc;
    repeat (40) tick();
    kif.key_db = 1'b1;
    repeat (15) tick();
    n++;
    if (dc_cyc - p !== 1) begin
      err++;
      $display("FAIL dclick_latency got %0d want 1", dc_cyc - p);
    end
    n++;
    if (dc_n !== 1 || sp_n !== 0 || lp_n !== 0 || kif.led !== 4'hE) begin
      err++;
      $display("FAIL dclick_events got dc=%0d sp=%0d lp=%0d led=%h want 1 0 0 e", dc_n, sp_n, lp_n, kif.led);
    end
  endtask
  task automatic test_wrap;
    logic [3:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_counts();
    exp = 4'h0;
    for (int i = 0; i < 17; i++) begin
      kif.key_db = 1'b0;
      repeat (2) tick();
      kif.key_db = 1'b1;
      repeat (13) tick();
      exp = exp + 4'h1;
      n++;
      if (kif.led !== exp) begin
        err++;
        $display("FAIL wrap_led i=%0d got %h want %h", i, kif.led, exp);
      end
    end
    n++;
    if (sp_n !== 17 || lp_n !== 0 || dc_n !== 0) begin
      err++;
      $display("FAIL wrap_count got sp=%0d lp=%0d dc=%0d want 17 0 0", sp_n, lp_n, dc_n);
    end
  endtask
  task automatic test_rst_gap;
    clear_counts();
    kif.key_db = 1'b0;
    repeat (3) tick();
    kif.key_db = 1'b1;
    tick();
    repeat (5) tick();
    n++;
    if (dut.cnt_q !== 5'd5) begin
      err++;
      $display("FAIL rst_gap_cnt got %0d want 5", dut.cnt_q);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    n++;
    if (sp_n !== 0 || lp_n !== 0 || dc_n !== 0 || kif.led !== 4'h0) begin
      err++;
      $display("FAIL rst_gap_events got sp=%0d lp=%0d dc=%0d led=%h want 0 0 0 0", sp_n, lp_n, dc_n, kif.led);
    end
    n++;
    if (2'(dut.state_q) !== 2'd0) begin
      err++;
      $display("FAIL rst_gap_idle got state=%0d want 0", 2'(dut.state_q));
    end
  endtask
  initial begin
    kif.key_db = 1'b1;
    clear_counts();
    test_reset();
    test_short();
    test_long();
    test_dclick();
    test_wrap();
    test_rst_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, err);
    $finish;
  end
endmodule
